bitplane_serializer: RTL and testbench

//  Parametrised bit-plane packet transmitter. On start it reads WORDS words of WIDTH bits from a read-only register bank.
//  For every bit plane it builds one packet: the plane index followed by that bit of each word. Each packet is shifted out

---
 rtl/bitplane_pkg.sv | 30 +++
 rtl/bitplane_serializer_shifter.sv | 75 +++++++
 rtl/bitplane_serializer.sv | 188 ++++++++++++++++++
 tb/tb_bitplane_serializer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitplane_pkg.sv
// Package: bitplane_pkg
//   Shared types and helpers for the bit-plane serializer.
//   - state_t   : controller states
//   - PARITY_EN : set when BITPLANE_PARITY_EN is defined (even parity bit
//                 appended to every packet)
//   - pkt_width : packet length in bits for a given configuration
package bitplane_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
      GAP,
      DONE
   } state_t;

`ifdef BITPLANE_PARITY_EN
   localparam bit PARITY_EN = 1'b1;
`else
   localparam bit PARITY_EN = 1'b0;
`endif

   // Packet = plane index + one bit per word (+ optional parity bit).
   function automatic int unsigned pkt_width(input int unsigned words,
                                             input int unsigned width,
                                             input bit          parity);
      return $clog2(width) + words + (parity ? 1 : 0);
   endfunction

endpackage

// File: rtl/bitplane_serializer_shifter.sv
// Module: bitplane_shifter
//   Packet buffer for one bit plane. Holds the plane index and one data bit
//   per word; when BITPLANE_PARITY_EN is defined an even-parity bit over
//   index+data is appended as the least significant packet bit.
//   Packet layout (MSB first on the wire): {index, word WORDS-1 .. word 0, [parity]}
// Ports:
//   clk     in  1     clock, falling-edge active
//   rst_n   in  1     asynchronous active-low reset (buffer cleared)
//   wr_en   in  1     store wr_bit into data slot wr_slot
//   wr_slot in  AW    data slot (word number)
//   wr_bit  in  1     data bit to store
//   idx_wr  in  1     store idx into the index field
//   idx     in  IW    plane index
//   sel     in  CW    packet bit to present on bit_out
//   bit_out out 1     selected packet bit (combinational)
module bitplane_shifter
   import bitplane_pkg::*;
#(
   parameter int unsigned WORDS = 18,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 5
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       wr_en,
   input  logic [AW-1:0]                              wr_slot,
   input  logic                                       wr_bit,
   input  logic                                       idx_wr,
   input  logic [$clog2(WIDTH)-1:0]                   idx,
   input  logic [$clog2(pkt_width(WORDS, WIDTH, PARITY_EN))-1:0] sel,
   output logic                                       bit_out
);

   localparam int unsigned IW    = $clog2(WIDTH);
   localparam int unsigned PKT_W = pkt_width(WORDS, WIDTH, PARITY_EN);
   localparam int unsigned CW    = $clog2(PKT_W);

   logic [IW-1:0]    idx_q;
   logic [WORDS-1:0] data_q;
   logic [PKT_W-1:0] pkt_v;

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= '0;
         data_q <= '0;
      end else begin
         if (idx_wr) begin
            idx_q <= idx;
         end
         for (int unsigned i = 0; i < WORDS; i++) begin
            if (wr_en && (wr_slot == AW'(i))) begin
               data_q[i] <= wr_bit;
            end
         end
      end
   end

   generate
      if (PARITY_EN) begin : g_par
         assign pkt_v = {idx_q, data_q, ^{idx_q, data_q}};
      end else begin : g_nopar
         assign pkt_v = {idx_q, data_q};
      end
   endgenerate

   always_comb begin
      bit_out = 1'b0;
      for (int unsigned i = 0; i < PKT_W; i++) begin
         if (sel == CW'(i)) begin
            bit_out = pkt_v[i];
         end
      end
   end

endmodule

// File: rtl/bitplane_serializer.sv
// Module: bitplane_serializer
//   Bit-plane packet transmitter. On start, for each of WIDTH bit planes it
//   reads WORDS words from a read-only register bank, builds a packet
//   {plane index, bit p of words WORDS-1..0 [, parity]} and shifts it out
//   MSB first on sd framed by active-low sen. All registers update on the
//   falling clock edge.
//   Optional feature: define BITPLANE_PARITY_EN to append an even-parity bit.
// Ports:
//   clk       in  1      clock (falling-edge active)
//   rst_n     in  1      asynchronous active-low reset
//   start     in  1      run request, sampled in IDLE
//   lsb_first in  1      0: plane WIDTH-1 first, 1: plane 0 first
//   busy      out 1      run in progress
//   done      out 1      one-cycle end-of-run pulse
//   rb_rw     out 1      bank read/write, always read (1)
//   rb_a      out AW     bank address
//   rb_q      in  WIDTH  bank data for rb_a, valid at the next falling edge
//   sen       out 1      frame enable, low while packet bits are driven
//   sd        out 1      serial data
module bitplane_serializer
   import bitplane_pkg::*;
#(
   parameter int unsigned WORDS = 18,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             lsb_first,
   output logic             busy,
   output logic             done,
   output logic             rb_rw,
   output logic [AW-1:0]    rb_a,
   input  logic [WIDTH-1:0] rb_q,
   output logic             sen,
   output logic             sd
);

   localparam int unsigned IW    = $clog2(WIDTH);
   localparam int unsigned PKT_W = pkt_width(WORDS, WIDTH, PARITY_EN);
   localparam int unsigned CW    = $clog2(PKT_W);

   state_t          state_q, state_d;
   logic [IW-1:0]   plane_q, plane_d;
   logic            lsb_q, lsb_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   rb_a_q, rb_a_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            sen_q, sen_d;
   logic            sd_q, sd_d;

   logic            wr_en;
   logic            idx_wr;
   logic            wr_bit;
   logic [CW-1:0]   sel;
   logic            bit_out;
   logic [IW-1:0]   last_plane;

   assign wr_bit     = rb_q[plane_q];
   assign last_plane = lsb_q ? '1 : '0;

   bitplane_shifter #(
      .WORDS (WORDS),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_slot (rb_a_q),
      .wr_bit  (wr_bit),
      .idx_wr  (idx_wr),
      .idx     (plane_q),
      .sel     (sel),
      .bit_out (bit_out)
   );

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         plane_q <= '0;
         lsb_q   <= 1'b0;
         cnt_q   <= '0;
         rb_a_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sen_q   <= 1'b1;
         sd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         plane_q <= plane_d;
         lsb_q   <= lsb_d;
         cnt_q   <= cnt_d;
         rb_a_q  <= rb_a_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sen_q   <= sen_d;
         sd_q    <= sd_d;
      end
   end

   // sd/sen are registered, so each edge drives the bit for the cycle that
   // follows: the last LOAD edge already presents the index MSB (written on
   // the first LOAD edge), and SEND presents bit cnt-1 while counting down.
   // This keeps sen low for exactly PKT_W cycles per packet.
   always_comb begin
      state_d = state_q;
      plane_d = plane_q;
      lsb_d   = lsb_q;
      cnt_d   = cnt_q;
      rb_a_d  = rb_a_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      sen_d   = sen_q;
      sd_d    = sd_q;
      wr_en   = 1'b0;
      idx_wr  = 1'b0;
      sel     = '0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               lsb_d   = lsb_first;
               plane_d = lsb_first ? '0 : '1;
               rb_a_d  = '0;
               busy_d  = 1'b1;
               state_d = LOAD;
            end
         end

         LOAD: begin
            wr_en  = 1'b1;
            idx_wr = (rb_a_q == '0);
            if (rb_a_q == AW'(WORDS - 1)) begin
               cnt_d   = CW'(PKT_W - 1);
               sel     = CW'(PKT_W - 1);
               sen_d   = 1'b0;
               sd_d    = bit_out;
               state_d = SEND;
            end else begin
               rb_a_d = rb_a_q + AW'(1);
            end
         end

         SEND: begin
            if (cnt_q == '0) begin
               sen_d   = 1'b1;
               sd_d    = 1'b0;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - CW'(1);
               sel   = cnt_q - CW'(1);
               sd_d  = bit_out;
            end
         end

         GAP: begin
            if (plane_q == last_plane) begin
               done_d  = 1'b1;
               state_d = DONE;
            end else begin
               plane_d = lsb_q ? plane_q + IW'(1) : plane_q - IW'(1);
               rb_a_d  = '0;
               state_d = LOAD;
            end
         end

         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign rb_rw = 1'b1;
   assign rb_a  = rb_a_q;
   assign sen   = sen_q;
   assign sd    = sd_q;

endmodule

// File: tb/tb_bitplane_serializer.sv
module tb_bitplane_serializer;

`ifdef BITPLANE_PARITY_EN
   localparam int WORDS  = 4;
   localparam int WIDTH  = 4;
   localparam int AW     = 2;
   localparam int PAR_EN = 1;
`else
   localparam int WORDS  = 18;
   localparam int WIDTH  = 8;
   localparam int AW     = 5;
   localparam int PAR_EN = 0;
`endif
   localparam int IW      = $clog2(WIDTH);
   localparam int PKT_W   = IW + WORDS + PAR_EN;
   localparam int RUN_LEN = WIDTH * (WORDS + PKT_W + 1) + 1;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic             lsb_first;
   logic             busy;
   logic             done;
   logic             rb_rw;
   logic [AW-1:0]    rb_a;
   logic [WIDTH-1:0] rb_q;
   logic             sen;
   logic             sd;

   logic [WIDTH-1:0] bank [0:(2**AW)-1];

   int errors = 0;
   int checks = 0;

   bit          exp_q[$];
   bit          mon_en = 1'b0;
   int          pkt_cnt;
   int          low_run;
   int          high_run;
   logic [63:0] first_pkt;
   bit          e_bit;

   typedef struct {
      int               fill_mode;  // 0: all words = fill, 1: word i = i, 2: top word all ones
      logic [WIDTH-1:0] fill;
      bit               lsb;
      bit               pulse;      // pulse start while a packet is on the wire
      logic [63:0]      exp_first;
   } vec_t;

   vec_t vecs[4];

   bitplane_serializer #(
      .WORDS (WORDS),
      .WIDTH (WIDTH),
      .AW    (AW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .lsb_first (lsb_first),
      .busy      (busy),
      .done      (done),
      .rb_rw     (rb_rw),
      .rb_a      (rb_a),
      .rb_q      (rb_q),
      .sen       (sen),
      .sd        (sd)
   );

   assign rb_q = bank[rb_a];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fill_bank(input int mode, input logic [WIDTH-1:0] v);
      for (int i = 0; i < 2**AW; i++) bank[i] = '0;
      for (int i = 0; i < WORDS; i++) begin
         case (mode)
            0:       bank[i] = v;
            1:       bank[i] = WIDTH'(i);
            default: bank[i] = (i == WORDS - 1) ? '1 : '0;
         endcase
      end
   endtask

   // Expected wire bits of a whole run, in transmission order.
   task automatic build_model(input bit lsb);
      int p;
      bit par;
      bit v;
      exp_q.delete();
      p = lsb ? 0 : WIDTH - 1;
      for (int k = 0; k < WIDTH; k++) begin
         par = 1'b0;
         for (int b = IW - 1; b >= 0; b--) begin
            exp_q.push_back(p[b]);
            par ^= p[b];
         end
         for (int w = WORDS - 1; w >= 0; w--) begin
            v = bank[w][p];
            exp_q.push_back(v);
            par ^= v;
         end
         if (PAR_EN != 0) exp_q.push_back(par);
         p = lsb ? p + 1 : p - 1;
      end
   endtask

   // Scoreboard / framing monitor, sampling mid-cycle (rising edge).
   always @(posedge clk) begin
      if (mon_en) begin
         chk("rb_a range", 64'(int'(rb_a) < WORDS), 64'd1);
         if (sen === 1'b0) begin
            if (low_run == 0 && pkt_cnt > 0) chk("gap length", 64'(high_run), 64'(WORDS + 1));
            low_run++;
            high_run = 0;
            if (exp_q.size() == 0) begin
               chk("extra packet bit", 64'd1, 64'd0);
            end else begin
               e_bit = exp_q.pop_front();
               chk("packet bit", 64'(sd), 64'(e_bit));
            end
            if (pkt_cnt == 0) first_pkt = {first_pkt[62:0], sd};
         end else begin
            if (low_run != 0) begin
               chk("sen low length", 64'(low_run), 64'(PKT_W));
               pkt_cnt++;
               low_run = 0;
            end
            high_run++;
         end
      end
   end

   task automatic run_one(input bit lsb, input bit pulse, input bit hold,
                          input logic [63:0] exp_first, input string tag);
      int n;
      bit pulsed;
      build_model(lsb);
      pkt_cnt   = 0;
      low_run   = 0;
      high_run  = 0;
      first_pkt = '0;
      pulsed    = 1'b0;
      mon_en    = 1'b1;
      @(posedge clk); #1;
      start     = 1'b1;
      lsb_first = lsb;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      n = 1;
      chk({tag, " busy after accept"}, 64'(busy), 64'd1);
      while (done !== 1'b1 && n < RUN_LEN + 50) begin
         @(posedge clk); #1;
         n++;
         if (pulse && !pulsed && sen === 1'b0) begin
            start = 1'b1;
            @(posedge clk); #1;
            n++;
            start  = 1'b0;
            pulsed = 1'b1;
         end
      end
      chk({tag, " cycles to done"}, 64'(n), 64'(RUN_LEN));
      if (hold) begin
         chk({tag, " packets"}, 64'(pkt_cnt), 64'(WIDTH));
         mon_en = 1'b0;
         @(posedge clk); #1;
         chk({tag, " busy drops"}, 64'(busy), 64'd0);
         @(posedge clk); #1;
         chk({tag, " restart with held start"}, 64'(busy), 64'd1);
         start = 1'b0;
         rst_n = 1'b0;
         @(posedge clk); #1;
         rst_n = 1'b1;
      end else begin
         repeat (5) @(posedge clk);
         #1;
         chk({tag, " busy after run"}, 64'(busy), 64'd0);
         chk({tag, " done after run"}, 64'(done), 64'd0);
         mon_en = 1'b0;
         chk({tag, " packets"}, 64'(pkt_cnt), 64'(WIDTH));
         chk({tag, " bits left"}, 64'(exp_q.size()), 64'd0);
         chk({tag, " first packet"}, first_pkt, exp_first);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " sen"}, 64'(sen), 64'd1);
      chk({tag, " sd"}, 64'(sd), 64'd0);
      chk({tag, " busy"}, 64'(busy), 64'd0);
      chk({tag, " done"}, 64'(done), 64'd0);
      chk({tag, " rb_a"}, 64'(rb_a), 64'd0);
      chk({tag, " rb_rw"}, 64'(rb_rw), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
`ifdef BITPLANE_PARITY_EN
      vecs[0] = '{fill_mode: 2, fill: 4'h0, lsb: 1'b0, pulse: 1'b0, exp_first: 64'b11_1000_1};
      vecs[1] = '{fill_mode: 2, fill: 4'h0, lsb: 1'b1, pulse: 1'b1, exp_first: 64'b00_1000_1};
      vecs[2] = '{fill_mode: 1, fill: 4'h0, lsb: 1'b1, pulse: 1'b0, exp_first: 64'b00_1010_0};
      vecs[3] = '{fill_mode: 0, fill: 4'h5, lsb: 1'b0, pulse: 1'b0, exp_first: 64'b11_0000_0};
`else
      vecs[0] = '{fill_mode: 0, fill: 8'hA5, lsb: 1'b0, pulse: 1'b0,
                  exp_first: 64'b111_111111111111111111};
      vecs[1] = '{fill_mode: 1, fill: 8'h00, lsb: 1'b1, pulse: 1'b1,
                  exp_first: 64'b000_101010101010101010};
      vecs[2] = '{fill_mode: 1, fill: 8'h00, lsb: 1'b0, pulse: 1'b0,
                  exp_first: 64'b111_000000000000000000};
      vecs[3] = '{fill_mode: 0, fill: 8'hA5, lsb: 1'b1, pulse: 1'b0,
                  exp_first: 64'b000_111111111111111111};
`endif
      rst_n     = 1'b1;
      start     = 1'b0;
      lsb_first = 1'b0;
      fill_bank(0, '0);
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_n = 1'b1;

      for (int v = 0; v < 4; v++) begin
         fill_bank(vecs[v].fill_mode, vecs[v].fill);
         run_one(vecs[v].lsb, vecs[v].pulse, 1'b0, vecs[v].exp_first, $sformatf("vec%0d", v));
      end

      // start held high across done: new run follows after one idle cycle
      fill_bank(1, '0);
      run_one(1'b0, 1'b0, 1'b1, '0, "held");
      chk_reset_vals("held abort");

      // reset in the middle of a packet
      fill_bank(0, '1);
      @(posedge clk); #1;
      start     = 1'b1;
      lsb_first = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      n = 0;
      while (sen !== 1'b0 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("midrun reached SEND", 64'(sen), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_reset_vals("midrun reset");
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("midrun stays idle", 64'(busy), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
